pe_mac_seq: RTL and testbench

- Sequencer for one pe_mac accumulator. Accepts a dot-product command (length, activation/weight base addresses, bias), streams reads from the activation and weight buffers, and drives the pe_mac en/clear_acc/bias inputs aligned to buffer read latency.
- Waits out the MAC pipeline, captures the final 32-bit sum and presents it on a valid/ready result port.
- Sits between the layer scheduler (command side) and the pe_mac + on-chip buffers (datapath side).

---
 rtl/pe_mac_seq.sv | 150 +++++++++++++++
 tb/tb_pe_mac_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_seq.sv
// pe_mac_seq: issues buffer reads and pe_mac controls for one dot product.
// Ports: cmd_* (command in), a_/w_rd_* (buffer reads), mac_* (pe_mac),
// res_* (result out), busy. Optional cmd_abort via PE_MAC_SEQ_ABORT_EN.
module pe_mac_seq #(
  parameter int ADDR_W  = 12,
  parameter int LEN_W   = 12,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
`ifdef PE_MAC_SEQ_ABORT_EN
  input  logic              cmd_abort,
`endif
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_a_base,
  input  logic [ADDR_W-1:0] cmd_w_base,
  input  logic [31:0]       cmd_bias,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              mac_en,
  output logic              mac_clear_acc,
  output logic [31:0]       mac_bias,
  input  logic [31:0]       mac_dout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              busy
);

  localparam int DRN = RD_LAT + MAC_LAT;
  localparam int CW  = $clog2(DRN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [ADDR_W-1:0] a_base_q;
  logic [ADDR_W-1:0] w_base_q;
  logic [31:0]       bias_q;
  logic [31:0]       res_q;
  logic [CW-1:0]     cnt;
  logic [RD_LAT-1:0] stb_d;
  logic [RD_LAT-1:0] fst_d;
  logic              issue;
  logic              abort;
  logic [ADDR_W-1:0] off;

`ifdef PE_MAC_SEQ_ABORT_EN
  assign abort = cmd_abort && (state != S_IDLE);
`else
  assign abort = 1'b0;
`endif

  assign issue = (state == S_ISSUE);
  assign off   = ADDR_W'(idx);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= S_IDLE;
      len_q    <= '0;
      idx      <= '0;
      a_base_q <= '0;
      w_base_q <= '0;
      bias_q   <= '0;
      res_q    <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            len_q    <= cmd_len;
            a_base_q <= cmd_a_base;
            w_base_q <= cmd_w_base;
            bias_q   <= cmd_bias;
            idx      <= '0;
            if (cmd_len == '0) begin
              res_q <= cmd_bias;
              state <= S_OUT;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          idx <= idx + 1'b1;
          if (idx == len_q - 1'b1) begin
            cnt   <= CW'(DRN - 1);
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            res_q <= mac_dout;
            state <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (abort) begin
        state <= S_IDLE;
        idx   <= '0;
      end
    end
  end

  // Strobe and first-term flag follow the buffer read latency so that
  // mac_en lines up with the read data reaching pe_mac.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stb_d <= '0;
      fst_d <= '0;
    end else if (abort) begin
      stb_d <= '0;
      fst_d <= '0;
    end else begin
      for (int k = RD_LAT - 1; k > 0; k--) begin
        stb_d[k] <= stb_d[k-1];
        fst_d[k] <= fst_d[k-1];
      end
      stb_d[0] <= issue;
      fst_d[0] <= (idx == '0);
    end
  end

  assign cmd_ready     = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign a_rd_en       = issue;
  assign w_rd_en       = issue;
  assign a_rd_addr     = a_base_q + off;
  assign w_rd_addr     = w_base_q + off;
  assign mac_en        = stb_d[RD_LAT-1];
  assign mac_clear_acc = stb_d[RD_LAT-1] & fst_d[RD_LAT-1];
  assign mac_bias      = bias_q;
  assign res_valid     = (state == S_OUT);
  assign res_data      = res_q;

endmodule

// File: tb/tb_pe_mac_seq.sv
// tb_pe_mac_seq: directed bench for pe_mac_seq with buffer and pe_mac
// models. Define PE_MAC_SEQ_ABORT_EN to also exercise cmd_abort.
module tb_pe_mac_seq;

  logic        aclk = 0;
  logic        aresetn = 0;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic [11:0] cmd_len = 0;
  logic [11:0] cmd_a_base = 0;
  logic [11:0] cmd_w_base = 0;
  logic [31:0] cmd_bias = 0;
  logic        a_rd_en, w_rd_en;
  logic [11:0] a_rd_addr, w_rd_addr;
  logic        mac_en, mac_clear_acc;
  logic [31:0] mac_bias;
  logic [31:0] mac_dout;
  logic        res_valid;
  logic        res_ready = 0;
  logic [31:0] res_data;
  logic        busy;
`ifdef PE_MAC_SEQ_ABORT_EN
  logic        cmd_abort = 0;
`endif

  pe_mac_seq dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
`ifdef PE_MAC_SEQ_ABORT_EN
    .cmd_abort(cmd_abort),
`endif
    .cmd_len(cmd_len), .cmd_a_base(cmd_a_base),
    .cmd_w_base(cmd_w_base), .cmd_bias(cmd_bias),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .mac_en(mac_en), .mac_clear_acc(mac_clear_acc),
    .mac_bias(mac_bias), .mac_dout(mac_dout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy)
  );

  always #5 aclk = ~aclk;

  logic signed [31:0] act_mem [4096];
  logic signed [31:0] wt_mem  [4096];
  logic signed [31:0] a_q, w_q;

  always @(posedge aclk) begin
    if (a_rd_en) a_q <= act_mem[a_rd_addr];
    if (w_rd_en) w_q <= wt_mem[w_rd_addr];
  end

  logic               en_r, clr_r;
  logic signed [31:0] a_r, w_r;
  logic [31:0]        b_r, acc;
  assign mac_dout = acc;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_r <= 0; clr_r <= 0; a_r <= 0; w_r <= 0; b_r <= 0; acc <= 0;
    end else begin
      en_r  <= mac_en;
      clr_r <= mac_clear_acc;
      a_r   <= a_q;
      w_r   <= w_q;
      b_r   <= mac_bias;
      if (en_r) acc <= (clr_r ? b_r : acc) + 32'(a_r * w_r);
    end
  end

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [11:0] a_addr_q [$];
  logic [11:0] w_addr_q [$];
  logic        clr_q [$];
  int          rd_cnt = 0;
  int          rv_cnt = 0;
  always @(negedge aclk) begin
    if (a_rd_en) begin
      a_addr_q.push_back(a_rd_addr);
      w_addr_q.push_back(w_rd_addr);
      rd_cnt++;
    end
    if (mac_en) clr_q.push_back(mac_clear_acc);
    if (res_valid) rv_cnt++;
  end

  int nchk = 0;
  int nfail = 0;
  int c0, lat;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [11:0] len, input logic [11:0] ab,
                      input logic [11:0] wb, input logic [31:0] bias);
    @(posedge aclk); #1;
    cmd_len = len; cmd_a_base = ab; cmd_w_base = wb; cmd_bias = bias;
    cmd_valid = 1;
    c0 = cyc;
    @(posedge aclk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_res();
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (res_valid) begin
        lat = cyc - c0;
        break;
      end
    end
  endtask

  task automatic take_res();
    res_ready = 1;
    @(posedge aclk); #1;
    res_ready = 0;
    @(negedge aclk);
    chk("idle_after_hs", {30'd0, res_valid, cmd_ready}, 32'd1);
  endtask

  int s_rd, s_en, s_rv;
  logic [3:0] pat;
  logic [31:0] hold;
  logic stable;

  initial begin
    for (int k = 0; k < 4096; k++) begin
      act_mem[k] = 0;
      wt_mem[k]  = 0;
    end
    act_mem[12'h010] = 1; act_mem[12'h011] = 2;
    act_mem[12'h012] = 3; act_mem[12'h013] = 4;
    wt_mem[12'h020] = 5;  wt_mem[12'h021] = -1;
    wt_mem[12'h022] = 2;  wt_mem[12'h023] = 3;
    act_mem[12'h030] = 3; act_mem[12'h031] = -4;
    wt_mem[12'h040] = 7;  wt_mem[12'h041] = 2;
    act_mem[12'h050] = 10; act_mem[12'h051] = 20;
    wt_mem[12'h060] = 1;  wt_mem[12'h061] = 1;
    act_mem[12'hFFE] = 2; act_mem[12'hFFF] = 3;
    act_mem[12'h000] = 4; act_mem[12'h001] = 5;
    for (int k = 0; k < 8; k++) begin
      act_mem[12'h200 + k] = k + 1;
      wt_mem[12'h300 + k]  = 2;
      wt_mem[12'h100 + k]  = 1;
    end
    act_mem[12'h600] = 6; wt_mem[12'h700] = 7;

    // reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_ctl", {25'd0, cmd_ready, a_rd_en, w_rd_en, mac_en,
        mac_clear_acc, res_valid, busy}, 32'h40);
    #2 aresetn = 1;

    // len=4 basic dot product
    s_rd = rd_cnt; s_en = clr_q.size();
    send(12'd4, 12'h010, 12'h020, 32'd100);
    wait_res();
    chk("t1_lat", lat, 8);
    chk("t1_data", res_data, 32'd121);
    chk("t1_rd_cnt", rd_cnt - s_rd, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_a_addr", {20'd0, a_addr_q[s_rd + k]}, 32'h010 + k);
      chk("t1_w_addr", {20'd0, w_addr_q[s_rd + k]}, 32'h020 + k);
    end
    chk("t1_en_cnt", clr_q.size() - s_en, 4);
    for (int k = 0; k < 4; k++) pat[3-k] = clr_q[s_en + k];
    chk("t1_clr_pat", {28'd0, pat}, 32'h8);
    take_res();

    // len=0
    s_rd = rd_cnt; s_en = clr_q.size();
    send(12'd0, 12'h010, 12'h020, 32'hFFFF_FFF9);
    wait_res();
    chk("t2_lat", lat, 1);
    chk("t2_data", res_data, 32'hFFFF_FFF9);
    take_res();
    chk("t2_no_rd", rd_cnt - s_rd, 0);
    chk("t2_no_en", clr_q.size() - s_en, 0);

    // backpressure then second command
    send(12'd2, 12'h030, 12'h040, 32'd1);
    wait_res();
    chk("t3_lat", lat, 6);
    chk("t3_data", res_data, 32'd14);
    hold = res_data;
    stable = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      if (!res_valid || res_data !== hold || cmd_ready) stable = 0;
    end
    chk("t3_stable", {31'd0, stable}, 32'd1);
    take_res();
    s_en = clr_q.size();
    send(12'd2, 12'h050, 12'h060, 32'd0);
    wait_res();
    chk("t3b_data", res_data, 32'd30);
    chk("t3b_clr", {31'd0, clr_q[s_en]}, 32'd1);
    take_res();

    // address wrap
    s_rd = rd_cnt;
    send(12'd4, 12'hFFE, 12'h100, 32'd0);
    wait_res();
    chk("t4_data", res_data, 32'd14);
    chk("t4_a0", {20'd0, a_addr_q[s_rd]},     32'hFFE);
    chk("t4_a1", {20'd0, a_addr_q[s_rd + 1]}, 32'hFFF);
    chk("t4_a2", {20'd0, a_addr_q[s_rd + 2]}, 32'h000);
    chk("t4_a3", {20'd0, a_addr_q[s_rd + 3]}, 32'h001);
    take_res();

    // reset during DRAIN
    send(12'd8, 12'h200, 12'h300, 32'd10);
    repeat (9) @(posedge aclk);
    @(negedge aclk);
    chk("t5_in_drain", {31'd0, busy & ~a_rd_en}, 32'd1);
    aresetn = 0;
    #1;
    chk("t5_rst_ctl", {25'd0, cmd_ready, a_rd_en, w_rd_en, mac_en,
        mac_clear_acc, res_valid, busy}, 32'h40);
    chk("t5_rst_addr", {8'd0, a_rd_addr, w_rd_addr}, 32'd0);
    chk("t5_rst_bias", mac_bias, 32'd0);
    chk("t5_rst_data", res_data, 32'd0);
    @(negedge aclk);
    aresetn = 1;
    s_rv = rv_cnt;
    repeat (12) @(negedge aclk);
    chk("t5_no_stale", rv_cnt - s_rv, 0);
    chk("t5_post_ctl", {25'd0, cmd_ready, a_rd_en, w_rd_en, mac_en,
        mac_clear_acc, res_valid, busy}, 32'h40);
    send(12'd8, 12'h200, 12'h300, 32'd10);
    wait_res();
    chk("t5_lat", lat, 12);
    chk("t5_data", res_data, 32'd82);
    take_res();

`ifdef PE_MAC_SEQ_ABORT_EN
    send(12'd16, 12'h400, 12'h500, 32'd3);
    @(posedge aclk); #1;
    cmd_abort = 1;
    @(posedge aclk); #1;
    cmd_abort = 0;
    @(negedge aclk);
    chk("t6_en_off", {30'd0, mac_en, a_rd_en}, 32'd0);
    s_en = clr_q.size();
    s_rv = rv_cnt;
    repeat (30) @(negedge aclk);
    chk("t6_no_en", clr_q.size() - s_en, 0);
    chk("t6_no_res", rv_cnt - s_rv, 0);
    send(12'd1, 12'h600, 12'h700, 32'd5);
    wait_res();
    chk("t6_data", res_data, 32'd47);
    take_res();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
